// File: rtl/reorder_buffer_if.sv
// Dispatch/execute/retire bundle for reorder_buffer. The master side drives
// allocation and completion; the slave side (the ROB) drives the rest.
interface reorder_buffer_if #(
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7,
  parameter int AREG_W = 5,
  parameter int PC_W   = 9
);
  logic              alloc_valid;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [PC_W-1:0]   alloc_pc;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_prd;
  logic [PREG_W-1:0] alloc_old_prd;
  logic              cmpl_valid;
  logic [TAG_W-1:0]  cmpl_tag;
  logic              cmpl_mispredict;
  logic [PC_W-1:0]   cmpl_target;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [PC_W-1:0]   commit_pc;
  logic [AREG_W-1:0] commit_rd;
  logic [PREG_W-1:0] commit_prd;
  logic              free_valid;
  logic [PREG_W-1:0] commit_old_prd;
  logic              flush_valid;
  logic [PC_W-1:0]   flush_pc;
  logic [TAG_W:0]    count;

  modport master (
    output alloc_valid, alloc_pc, alloc_rd, alloc_prd, alloc_old_prd,
    output cmpl_valid, cmpl_tag, cmpl_mispredict, cmpl_target,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_pc,
    input  commit_rd, commit_prd, free_valid, commit_old_prd,
    input  flush_valid, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rd, alloc_prd, alloc_old_prd,
    input  cmpl_valid, cmpl_tag, cmpl_mispredict, cmpl_target,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_pc,
    output commit_rd, commit_prd, free_valid, commit_old_prd,
    output flush_valid, flush_pc, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at dispatch, retires one completed
// head entry per cycle, flushes on a mispredicted branch. Option: ROB_CMPL_BYPASS_EN.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7,
  parameter int AREG_W = 5,
  parameter int PC_W   = 9
) (
  input logic              clk,
  input logic              rst,
  reorder_buffer_if.slave  bus
);
  localparam int PTR_W = TAG_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  done_r;
  logic [DEPTH-1:0]  misp_r;
  logic [PC_W-1:0]   pc_r      [DEPTH];
  logic [AREG_W-1:0] rd_r      [DEPTH];
  logic [PREG_W-1:0] prd_r     [DEPTH];
  logic [PREG_W-1:0] old_prd_r [DEPTH];
  logic [PC_W-1:0]   target_r  [DEPTH];

  logic [TAG_W-1:0] head_idx_s;
  logic [TAG_W-1:0] tail_idx_s;
  logic             full_s;
  logic             bypass_s;
  logic             commit_s;
  logic             flush_s;
  logic             ready_s;
  logic             push_s;
  logic             cmpl_ok_s;

  assign head_idx_s = head_r[TAG_W-1:0];
  assign tail_idx_s = tail_r[TAG_W-1:0];
  assign full_s     = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);

`ifdef ROB_CMPL_BYPASS_EN
  // A completion aimed at the not-yet-done head retires in the same cycle.
  assign bypass_s = bus.cmpl_valid && (bus.cmpl_tag == head_idx_s) &&
                    valid_r[head_idx_s] && !done_r[head_idx_s];
`else
  assign bypass_s = 1'b0;
`endif

  assign commit_s  = valid_r[head_idx_s] && (done_r[head_idx_s] || bypass_s);
  assign flush_s   = commit_s && (bypass_s ? bus.cmpl_mispredict : misp_r[head_idx_s]);
  // Reset is folded in so dispatch sees "not ready" while the block is held in reset.
  assign ready_s   = rst && !full_s && !flush_s;
  assign push_s    = bus.alloc_valid && ready_s;
  assign cmpl_ok_s = bus.cmpl_valid && valid_r[bus.cmpl_tag] &&
                     !(push_s && (bus.cmpl_tag == tail_idx_s));

  assign bus.alloc_ready    = ready_s;
  assign bus.alloc_tag      = tail_idx_s;
  assign bus.count          = tail_r - head_r;
  assign bus.commit_valid   = commit_s;
  assign bus.commit_tag     = head_idx_s;
  assign bus.commit_pc      = pc_r[head_idx_s];
  assign bus.commit_rd      = rd_r[head_idx_s];
  assign bus.commit_prd     = prd_r[head_idx_s];
  assign bus.commit_old_prd = old_prd_r[head_idx_s];
  assign bus.free_valid     = commit_s && (prd_r[head_idx_s] != {PREG_W{1'b0}});
  assign bus.flush_valid    = flush_s;
  assign bus.flush_pc       = bypass_s ? bus.cmpl_target : target_r[head_idx_s];

  // Pointer and entry state; later assignments win when a commit clears the
  // head entry that a completion touched in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
      misp_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]      <= {PC_W{1'b0}};
        rd_r[i]      <= {AREG_W{1'b0}};
        prd_r[i]     <= {PREG_W{1'b0}};
        old_prd_r[i] <= {PREG_W{1'b0}};
        target_r[i]  <= {PC_W{1'b0}};
      end
    end else if (flush_s) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
      misp_r  <= {DEPTH{1'b0}};
    end else begin
      if (cmpl_ok_s) begin
        done_r[bus.cmpl_tag]   <= 1'b1;
        misp_r[bus.cmpl_tag]   <= bus.cmpl_mispredict;
        target_r[bus.cmpl_tag] <= bus.cmpl_target;
      end
      if (push_s) begin
        valid_r[tail_idx_s]   <= 1'b1;
        done_r[tail_idx_s]    <= 1'b0;
        misp_r[tail_idx_s]    <= 1'b0;
        pc_r[tail_idx_s]      <= bus.alloc_pc;
        rd_r[tail_idx_s]      <= bus.alloc_rd;
        prd_r[tail_idx_s]     <= bus.alloc_prd;
        old_prd_r[tail_idx_s] <= bus.alloc_old_prd;
        tail_r                <= tail_r + PTR_ONE;
      end
      if (commit_s) begin
        valid_r[head_idx_s] <= 1'b0;
        done_r[head_idx_s]  <= 1'b0;
        head_r              <= head_r + PTR_ONE;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: stimulus queues expected commits, a
// negedge monitor pops and compares every retirement.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(4), .PREG_W(7), .AREG_W(5), .PC_W(9)) bus ();
  reorder_buffer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] tag;
    logic [8:0] pc;
    logic [4:0] rd;
    logic [6:0] prd;
    logic [6:0] old_prd;
    logic       free;
    logic       flush;
    logic [8:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic [8:0] m_pc  [16];
  logic [4:0] m_rd  [16];
  logic [6:0] m_prd [16];
  logic [6:0] m_old [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [8:0] pc, input logic [4:0] rd, input logic [6:0] prd,
                      input logic [6:0] old_prd, input logic [3:0] exp_tag);
    bus.alloc_valid   = 1'b1;
    bus.alloc_pc      = pc;
    bus.alloc_rd      = rd;
    bus.alloc_prd     = prd;
    bus.alloc_old_prd = old_prd;
    #1;
    check("alloc_ready", bus.alloc_ready, 64'd1);
    check("alloc_tag", bus.alloc_tag, exp_tag);
    m_pc[exp_tag]  = pc;
    m_rd[exp_tag]  = rd;
    m_prd[exp_tag] = prd;
    m_old[exp_tag] = old_prd;
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic expect_commit(input logic [3:0] tag, input logic flush, input logic [8:0] fpc,
                               input int dcyc);
    exp_t e;
    e.tag     = tag;
    e.pc      = m_pc[tag];
    e.rd      = m_rd[tag];
    e.prd     = m_prd[tag];
    e.old_prd = m_old[tag];
    e.free    = (m_prd[tag] != 7'd0);
    e.flush   = flush;
    e.fpc     = flush ? fpc : 9'h000;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + dcyc);
  endtask

  task automatic cmpl(input logic [3:0] tag, input logic misp, input logic [8:0] tgt);
    bus.cmpl_valid      = 1'b1;
    bus.cmpl_tag        = tag;
    bus.cmpl_mispredict = misp;
    bus.cmpl_target     = tgt;
    tick();
    bus.cmpl_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_alloc_ready", bus.alloc_ready, 64'd0);
    check("rst_count", bus.count, 64'd0);
    check("rst_alloc_tag", bus.alloc_tag, 64'd0);
    check("rst_commit_flush", {bus.commit_valid, bus.free_valid, bus.flush_valid}, 64'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rel_alloc_ready", bus.alloc_ready, 64'd1);
    check("rel_alloc_tag", bus.alloc_tag, 64'd0);
    check("rel_count", bus.count, 64'd0);
  endtask

  // Scoreboard monitor: every retirement must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    int   c;
    if (rst) begin
      if (bus.commit_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit: got tag=%0h want no commit (t=%0t)",
                   bus.commit_tag, $time);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          g.tag     = bus.commit_tag;
          g.pc      = bus.commit_pc;
          g.rd      = bus.commit_rd;
          g.prd     = bus.commit_prd;
          g.old_prd = bus.commit_old_prd;
          g.free    = bus.free_valid;
          g.flush   = bus.flush_valid;
          g.fpc     = bus.flush_valid ? bus.flush_pc : 9'h000;
          check("commit_fields", g, e);
          check("commit_cycle", cyc, c);
        end
      end else begin
        check("idle_free_flush", {bus.free_valid, bus.flush_valid}, 64'd0);
      end
    end
  end

  initial begin
    int pcs [5] = '{0, 4, 8, 12, 16};
    int prds[5] = '{32, 33, 0, 0, 34};
    bus.alloc_valid     = 1'b0;
    bus.alloc_pc        = 9'h000;
    bus.alloc_rd        = 5'd0;
    bus.alloc_prd       = 7'd0;
    bus.alloc_old_prd   = 7'd0;
    bus.cmpl_valid      = 1'b0;
    bus.cmpl_tag        = 4'd0;
    bus.cmpl_mispredict = 1'b0;
    bus.cmpl_target     = 9'h000;
    do_reset();

    // Five pushes, nothing completes yet.
    for (int i = 0; i < 5; i++)
      push(pcs[i][8:0], 5'(i + 1), prds[i][6:0], 7'(10 + i), 4'(i));
    check("count_5", bus.count, 64'd5);
    tick();
    tick();

    // In-order completion retires back to back.
    for (int t = 0; t < 5; t++) begin
      expect_commit(4'(t), 1'b0, 9'h000, 1);
      cmpl(4'(t), 1'b0, 9'h000);
    end
    tick();
    tick();
    check("count_drained", bus.count, 64'd0);

    // Out-of-order completion: youngest first, retire waits on the oldest.
    for (int i = 0; i < 3; i++)
      push(9'(9'h020 + 4 * i), 5'(6 + i), 7'(50 + i), 7'(20 + i), 4'(5 + i));
    cmpl(4'd7, 1'b0, 9'h000);
    tick();
    tick();
    cmpl(4'd6, 1'b0, 9'h000);
    tick();
    expect_commit(4'd5, 1'b0, 9'h000, 1);
    expect_commit(4'd6, 1'b0, 9'h000, 2);
    expect_commit(4'd7, 1'b0, 9'h000, 3);
    cmpl(4'd5, 1'b0, 9'h000);
    tick();
    tick();
    tick();
    check("count_ooo", bus.count, 64'd0);

    // Full buffer and wrap of the tail.
    do_reset();
    for (int i = 0; i < 16; i++)
      push(9'(4 * i), 5'(i), 7'(40 + i), 7'(64 + i), 4'(i));
    check("full_count", bus.count, 64'd16);
    check("full_ready", bus.alloc_ready, 64'd0);
    bus.alloc_valid = 1'b1;
    tick();
    bus.alloc_valid = 1'b0;
    check("full_reject", bus.count, 64'd16);
    expect_commit(4'd0, 1'b0, 9'h000, 1);
    cmpl(4'd0, 1'b0, 9'h000);
    check("full_commit_cycle_ready", bus.alloc_ready, 64'd0);
    tick();
    check("after_commit_ready", bus.alloc_ready, 64'd1);
    check("after_commit_count", bus.count, 64'd15);
    push(9'h1f0, 5'd31, 7'd99, 7'd98, 4'd0);
    check("refill_count", bus.count, 64'd16);

    // Mispredicted branch at tag 3 flushes tags 4..6.
    do_reset();
    for (int i = 0; i < 7; i++)
      push(9'(9'h080 + 4 * i), 5'(i + 1), 7'(60 + i), 7'(30 + i), 4'(i));
    for (int t = 0; t < 3; t++) begin
      expect_commit(4'(t), 1'b0, 9'h000, 1);
      cmpl(4'(t), 1'b0, 9'h000);
    end
    expect_commit(4'd3, 1'b1, 9'h040, 1);
    cmpl(4'd3, 1'b1, 9'h040);
    bus.alloc_valid = 1'b1;
    bus.alloc_pc    = 9'h0f0;
    #1;
    check("flush_ready", bus.alloc_ready, 64'd0);
    tick();
    bus.alloc_valid = 1'b0;
    check("flush_count", bus.count, 64'd0);
    check("flush_tag", bus.alloc_tag, 64'd0);
    cmpl(4'd4, 1'b0, 9'h000);
    tick();
    tick();
    check("stale_cmpl_count", bus.count, 64'd0);

    // Reset with entries in flight.
    for (int i = 0; i < 6; i++)
      push(9'(9'h100 + 4 * i), 5'(i + 2), 7'(70 + i), 7'(40 + i), 4'(i));
    check("pre_reset_count", bus.count, 64'd6);
    do_reset();

    tick();
    tick();
    tick();
    check("queue_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
